fpu_issue: RTL and testbench

- Initiator-side sequencer for the FPU execute unit: accepts one decoded FP instruction at a time, launches it to fpu_execute, waits for the result handshake (single- or multi-cycle: fdiv/fsqrt/fma), then drives FP-regfile, integer-regfile and fflags writeback.
- Sits between the core decode/issue stage and fpu_execute/fpu_register/fpu_csr.
- Strictly in order, one operation in flight; a pipeline flush aborts it.

---
 rtl/fp_wire.sv | 39 +++
 rtl/fpu_issue_wdog.sv | 38 +++
 rtl/fpu_issue.sv | 196 +++++++++++++++++++
 tb/tb_fpu_issue.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_wire.sv
// fp_wire: shared types and constants for the FPU issue sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fp_wire;

   // Sequencer states: accept, launch to execute, wait for result, write back.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      WB     = 2'd3
   } fp_issue_state_type;

   // Instruction fields captured at accept (the opaque op bundle is kept
   // separately because its width is a module parameter).
   typedef struct packed {
      logic [31:0] data1;
      logic [31:0] data2;
      logic [31:0] data3;
      logic [4:0]  waddr;
      logic        fwren;
      logic        wren;
      logic        fpuf;
   } fp_issue_in_type;

   // Writeback bundle presented to the FP regfile, integer regfile and CSR block.
   typedef struct packed {
      logic        fwr_en;
      logic        iwr_en;
      logic        flg_en;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [4:0]  flags;
   } fp_issue_out_type;

   // Invalid-operation flag reported when the watchdog abandons an op.
   localparam logic [4:0] fp_issue_nv_flag = 5'b10000;

endpackage

// File: rtl/fpu_issue_wdog.sv
// fpu_issue_wdog: watchdog for an outstanding FPU op (only built with FPU_ISSUE_WDOG_EN).
// Latency: expire is combinational from the counter register during the TIMEOUT-th WAIT cycle.
// Backpressure: none; it only observes the sequencer state.
// Ports: clock, reset (sync, active-high); clr clears the count (op launched);
//        active marks a WAIT cycle (counted); expire flags the TIMEOUT-th WAIT cycle.
`ifdef FPU_ISSUE_WDOG_EN
module fpu_issue_wdog
#(
   parameter int TIMEOUT = 64
)
(
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic active,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (active) begin
         cnt <= cnt + 1'b1;
      end
   end

   // cnt holds the number of WAIT cycles already completed, so this fires
   // in the TIMEOUT-th WAIT cycle.
   assign expire = active && (cnt == CW'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/fpu_issue.sv
// fpu_issue: in-order, single-outstanding sequencer between FP decode and fpu_execute.
// Latency: accept -> writeback 2 cycles minimum; one op per 3 cycles back-to-back.
// Backpressure: in_ready low from launch through writeback; busy stalls the core.
// Ports: clock/reset (sync, active-high); in_* decoded instruction (valid/ready);
//        flush kills the op in flight; exe_* launch/kill/result handshake with execute;
//        fwr_* / iwr_* / flg_* writeback; busy, err (sticky watchdog error).
// Build option: FPU_ISSUE_WDOG_EN enables the outstanding-op watchdog (TIMEOUT cycles).
module fpu_issue
   import fp_wire::*;
#(
   parameter int TIMEOUT = 64,
   parameter int OPW     = 12
)
(
   input  logic            clock,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [OPW-1:0]  in_op,
   input  logic [31:0]     in_data1,
   input  logic [31:0]     in_data2,
   input  logic [31:0]     in_data3,
   input  logic [4:0]      in_waddr,
   input  logic            in_fwren,
   input  logic            in_wren,
   input  logic            in_fpuf,
   input  logic            flush,
   output logic            exe_valid,
   output logic [OPW-1:0]  exe_op,
   output logic [31:0]     exe_data1,
   output logic [31:0]     exe_data2,
   output logic [31:0]     exe_data3,
   output logic            exe_kill,
   input  logic            exe_ready,
   input  logic [31:0]     exe_result,
   input  logic [4:0]      exe_flags,
   output logic            fwr_en,
   output logic [4:0]      fwr_addr,
   output logic [31:0]     fwr_data,
   output logic            iwr_en,
   output logic [4:0]      iwr_addr,
   output logic [31:0]     iwr_data,
   output logic            flg_en,
   output logic [4:0]      flg_data,
   output logic            busy,
   output logic            err
);

   fp_issue_state_type state, next_state;

   logic [OPW-1:0]   op_q;
   fp_issue_in_type  in_q;
   fp_issue_in_type  in_d;
   fp_issue_out_type out_q;

   logic in_ready_q;
   logic exe_valid_q;
   logic exe_kill_q;
   logic busy_q;
   logic err_q;

   logic accept;
   logic result_cap;
   logic kill;
   logic wdog_fire;
   logic wdog_expire;
   logic wait_active;

   assign in_d = '{data1: in_data1, data2: in_data2, data3: in_data3,
                   waddr: in_waddr, fwren: in_fwren, wren: in_wren, fpuf: in_fpuf};

   assign wait_active = (state == WAIT);

`ifdef FPU_ISSUE_WDOG_EN
   fpu_issue_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clock  (clock),
      .reset  (reset),
      .clr    (accept),
      .active (wait_active),
      .expire (wdog_expire)
   );
`else
   logic [31:0] unused_timeout;
   assign unused_timeout = 32'(TIMEOUT);
   assign wdog_expire    = 1'b0;
`endif

   // Next-state and event decode. Priority inside LAUNCH/WAIT is
   // flush > result > watchdog: a flushed op never writes back, and a result
   // arriving in the final watchdog cycle is still honoured.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      result_cap = 1'b0;
      kill       = 1'b0;
      wdog_fire  = 1'b0;
      case (state)
         IDLE: begin
            // A flush in IDLE squashes whatever decode is presenting this cycle.
            if (in_valid && !flush) begin
               accept     = 1'b1;
               next_state = LAUNCH;
            end
         end
         LAUNCH: begin
            if (flush) begin
               kill       = 1'b1;
               next_state = IDLE;
            end else if (exe_ready) begin
               result_cap = 1'b1;
               next_state = WB;
            end else begin
               next_state = WAIT;
            end
         end
         WAIT: begin
            if (flush) begin
               kill       = 1'b1;
               next_state = IDLE;
            end else if (exe_ready) begin
               result_cap = 1'b1;
               next_state = WB;
            end else if (wdog_expire) begin
               kill       = 1'b1;
               wdog_fire  = 1'b1;
               next_state = IDLE;
            end
         end
         WB: begin
            // Already committed: a flush here does not cancel the writeback.
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // All outputs are flops loaded from next-state decode, so exe_ready only
   // reaches the writeback ports through a register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         op_q        <= '0;
         in_q        <= '0;
         out_q       <= '0;
         in_ready_q  <= 1'b1;
         exe_valid_q <= 1'b0;
         exe_kill_q  <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state       <= next_state;
         in_ready_q  <= (next_state == IDLE);
         busy_q      <= (next_state != IDLE);
         exe_valid_q <= accept;
         exe_kill_q  <= kill;
         err_q       <= err_q | wdog_fire;

         out_q.fwr_en <= result_cap & in_q.fwren;
         // x0 is hardwired zero in the integer file; f0 is a real register.
         out_q.iwr_en <= result_cap & in_q.wren & (in_q.waddr != 5'd0);
         out_q.flg_en <= (result_cap & in_q.fpuf) | wdog_fire;

         if (accept) begin
            op_q <= in_op;
            in_q <= in_d;
         end

         if (result_cap) begin
            out_q.addr  <= in_q.waddr;
            out_q.data  <= exe_result;
            out_q.flags <= exe_flags;
         end else if (wdog_fire) begin
            out_q.flags <= fp_issue_nv_flag;
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign exe_valid = exe_valid_q;
   assign exe_op    = op_q;
   assign exe_data1 = in_q.data1;
   assign exe_data2 = in_q.data2;
   assign exe_data3 = in_q.data3;
   assign exe_kill  = exe_kill_q;
   assign fwr_en    = out_q.fwr_en;
   assign fwr_addr  = out_q.addr;
   assign fwr_data  = out_q.data;
   assign iwr_en    = out_q.iwr_en;
   assign iwr_addr  = out_q.addr;
   assign iwr_data  = out_q.data;
   assign flg_en    = out_q.flg_en;
   assign flg_data  = out_q.flags;
   assign busy      = busy_q;
   assign err       = err_q;

endmodule

// File: tb/tb_fpu_issue.sv
// tb_fpu_issue: scoreboard bench for fpu_issue.
// Latency: n/a (testbench).
// Backpressure: stimulus waits on in_ready before presenting each instruction.
`timescale 1ns/1ps
module tb_fpu_issue;

   localparam int OPW = 12;
`ifdef FPU_ISSUE_WDOG_EN
   localparam int TB_TIMEOUT = 8;
   localparam int MAXD       = 8;
`else
   localparam int TB_TIMEOUT = 64;
   localparam int MAXD       = 20;
`endif
   localparam int NONE = 1000;

   logic            clock;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [OPW-1:0]  in_op;
   logic [31:0]     in_data1, in_data2, in_data3;
   logic [4:0]      in_waddr;
   logic            in_fwren, in_wren, in_fpuf;
   logic            flush;
   logic            exe_valid;
   logic [OPW-1:0]  exe_op;
   logic [31:0]     exe_data1, exe_data2, exe_data3;
   logic            exe_kill;
   logic            exe_ready;
   logic [31:0]     exe_result;
   logic [4:0]      exe_flags;
   logic            fwr_en;
   logic [4:0]      fwr_addr;
   logic [31:0]     fwr_data;
   logic            iwr_en;
   logic [4:0]      iwr_addr;
   logic [31:0]     iwr_data;
   logic            flg_en;
   logic [4:0]      flg_data;
   logic            busy;
   logic            err;

   fpu_issue #(.TIMEOUT(TB_TIMEOUT), .OPW(OPW)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
      .in_waddr(in_waddr), .in_fwren(in_fwren), .in_wren(in_wren), .in_fpuf(in_fpuf),
      .flush(flush),
      .exe_valid(exe_valid), .exe_op(exe_op),
      .exe_data1(exe_data1), .exe_data2(exe_data2), .exe_data3(exe_data3),
      .exe_kill(exe_kill), .exe_ready(exe_ready), .exe_result(exe_result), .exe_flags(exe_flags),
      .fwr_en(fwr_en), .fwr_addr(fwr_addr), .fwr_data(fwr_data),
      .iwr_en(iwr_en), .iwr_addr(iwr_addr), .iwr_data(iwr_data),
      .flg_en(flg_en), .flg_data(flg_data),
      .busy(busy), .err(err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [OPW-1:0] op;
      logic [31:0]    d1, d2, d3;
   } launch_t;

   typedef struct {
      bit          kill, fwr, iwr, flg;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [4:0]  flags;
   } ev_t;

   launch_t lq[$];
   ev_t     eq[$];
   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the expectation queues whenever the DUT presents a launch
   // or a writeback/kill event.
   always @(negedge clock) begin : monitor
      launch_t l;
      ev_t     e;
      if (!reset) begin
         if (exe_valid) begin
            if (lq.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_launch: exe_valid=1 with no launch expected (t=%0t)", $time);
            end else begin
               l = lq.pop_front();
               chk("exe_op", exe_op, l.op);
               chk("exe_data1", exe_data1, l.d1);
               chk("exe_data2", exe_data2, l.d2);
               chk("exe_data3", exe_data3, l.d3);
            end
         end
         if (fwr_en || iwr_en || flg_en || exe_kill) begin
            if (eq.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_event: fwr=%0b iwr=%0b flg=%0b kill=%0b, none expected (t=%0t)",
                        fwr_en, iwr_en, flg_en, exe_kill, $time);
            end else begin
               e = eq.pop_front();
               chk("exe_kill", exe_kill, e.kill);
               chk("fwr_en", fwr_en, e.fwr);
               chk("iwr_en", iwr_en, e.iwr);
               chk("flg_en", flg_en, e.flg);
               if (e.fwr) begin
                  chk("fwr_addr", fwr_addr, e.addr);
                  chk("fwr_data", fwr_data, e.data);
               end
               if (e.iwr) begin
                  chk("iwr_addr", iwr_addr, e.addr);
                  chk("iwr_data", iwr_data, e.data);
               end
               if (e.flg) chk("flg_data", flg_data, e.flags);
            end
         end
      end
   end

   // One instruction. dly: cycle (0 = LAUNCH) in which execute answers;
   // fl: cycle in which flush is raised (NONE = never). The expected outcome
   // follows directly from the rules: flush at or before the answer kills it.
   task automatic run_op(input logic [OPW-1:0] op, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] d3, input logic [4:0] wa, input logic fw,
                         input logic wr, input logic fu, input int dly, input int fl,
                         input logic [31:0] res, input logic [4:0] flg,
                         input bit idle_flush, input bit wb_flush);
      int  guard = 0;
      bit  killed;
      ev_t e;
      while (in_ready !== 1'b1 && guard < 50) begin
         @(negedge clock);
         guard++;
      end
      chk("in_ready_wait", 64'(guard < 50), 64'd1);
      in_op = op; in_data1 = d1; in_data2 = d2; in_data3 = d3;
      in_waddr = wa; in_fwren = fw; in_wren = wr; in_fpuf = fu;
      in_valid = 1'b1;
      lq.push_back('{op, d1, d2, d3});
      killed  = (fl <= dly);
      e.kill  = killed;
      e.fwr   = !killed && fw;
      e.iwr   = !killed && wr && (wa != 5'd0);
      e.flg   = !killed && fu;
      e.addr  = wa;
      e.data  = res;
      e.flags = flg;
      if (e.kill || e.fwr || e.iwr || e.flg) eq.push_back(e);
      if (idle_flush) begin
         flush = 1'b1;
         @(negedge clock);
         flush = 1'b0;
      end
      @(negedge clock);
      in_valid = 1'b0;
      in_op = OPW'($urandom); in_data1 = $urandom; in_data2 = $urandom; in_data3 = $urandom;
      in_waddr = 5'($urandom); in_fwren = 1'($urandom); in_wren = 1'($urandom); in_fpuf = 1'($urandom);
      for (int k = 0; k <= MAXD + 2; k++) begin
         chk("busy_active", busy, 1);
         chk("in_ready_active", in_ready, 0);
         exe_ready  = (k == dly);
         flush      = (k == fl);
         exe_result = (k == dly) ? res : $urandom;
         exe_flags  = (k == dly) ? flg : 5'($urandom);
         if (k == dly || k == fl) break;
         @(negedge clock);
      end
      @(negedge clock);
      exe_ready = 1'b0;
      flush     = 1'b0;
      if (killed) begin
         chk("in_ready_after_kill", in_ready, 1);
         chk("busy_after_kill", busy, 0);
         exe_ready  = 1'b1;          // late result after the kill must be ignored
         exe_result = $urandom;
         @(negedge clock);
         exe_ready = 1'b0;
      end else begin
         chk("busy_wb", busy, 1);
         chk("in_ready_wb", in_ready, 0);
         exe_ready  = 1'($urandom);
         exe_result = $urandom;
         flush      = wb_flush;
         @(negedge clock);
         exe_ready = 1'b0;
         flush     = 1'b0;
         chk("busy_after_wb", busy, 0);
         chk("in_ready_after_wb", in_ready, 1);
      end
   endtask

   initial begin : timeout_guard
      #2000000;
      $display("FAIL global_timeout: bench did not complete");
      $fatal(1);
   end

   initial begin : stimulus
      reset = 1'b1; in_valid = 1'b0; in_op = '0; in_data1 = '0; in_data2 = '0; in_data3 = '0;
      in_waddr = '0; in_fwren = 1'b0; in_wren = 1'b0; in_fpuf = 1'b0; flush = 1'b0;
      exe_ready = 1'b0; exe_result = '0; exe_flags = '0;
      repeat (3) @(negedge clock);
      reset = 1'b0;

      // Reset state.
      chk("rst_in_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_exe_valid", exe_valid, 0);
      chk("rst_exe_kill", exe_kill, 0);
      chk("rst_fwr_en", fwr_en, 0);
      chk("rst_iwr_en", iwr_en, 0);
      chk("rst_flg_en", flg_en, 0);
      chk("rst_err", err, 0);
      chk("rst_exe_op", exe_op, 0);
      chk("rst_exe_data1", exe_data1, 0);
      chk("rst_fwr_data", fwr_data, 0);

      // Single-cycle op to f3.
      run_op(12'h0A1, 32'h3F800000, 32'h0, 32'h0, 5'd3, 1, 0, 1, 0, NONE,
             32'h3F800000, 5'b00000, 0, 0);
      // Multi-cycle fdiv.
      run_op(12'h1C3, 32'h40490FDB, 32'h3F800000, 32'h0, 5'd9, 1, 0, 1,
             (MAXD < 17) ? MAXD : 17, NONE, 32'h40490FDB, 5'b00001, 0, 0);
      // Flush in WAIT cycle 5, execute answering later.
      run_op(12'h1C3, 32'h11111111, 32'h22222222, 32'h0, 5'd4, 1, 0, 1, NONE, 5,
             32'hDEADBEEF, 5'b00001, 0, 0);
      // Flush and result in the same cycle.
      run_op(12'h055, 32'h1, 32'h2, 32'h3, 5'd6, 1, 1, 1, 3, 3, 32'hCAFEF00D, 5'b00100, 0, 0);
      // fcmp to x0 and to x5.
      run_op(12'h2A0, 32'h3F800000, 32'h40000000, 32'h0, 5'd0, 0, 1, 1, 0, NONE,
             32'h00000001, 5'b10000, 0, 0);
      run_op(12'h2A0, 32'h3F800000, 32'h40000000, 32'h0, 5'd5, 0, 1, 1, 2, NONE,
             32'h00000001, 5'b00000, 0, 0);
      // Both regfiles written; FP f0 written normally.
      run_op(12'h3FF, 32'hA, 32'hB, 32'hC, 5'd7, 1, 1, 0, 1, NONE, 32'h12345678, 5'b0, 0, 0);
      run_op(12'h001, 32'hA, 32'hB, 32'hC, 5'd0, 1, 0, 0, 0, NONE, 32'h87654321, 5'b0, 0, 0);
      // Flush in WB completes the writeback; flush in IDLE squashes one cycle.
      run_op(12'h777, 32'h5, 32'h6, 32'h7, 5'd12, 1, 0, 1, 4, NONE, 32'h55AA55AA, 5'b00010, 0, 1);
      run_op(12'h3C3, 32'h8, 32'h9, 32'hA, 5'd13, 0, 1, 0, 1, NONE, 32'hAA55AA55, 5'b0, 1, 0);

      // Reset in the middle of WAIT drops the op silently.
      in_op = 12'h4B4; in_data1 = 32'h1; in_data2 = 32'h2; in_data3 = 32'h3;
      in_waddr = 5'd8; in_fwren = 1'b1; in_wren = 1'b1; in_fpuf = 1'b1; in_valid = 1'b1;
      lq.push_back('{12'h4B4, 32'h1, 32'h2, 32'h3});
      @(negedge clock);
      in_valid = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_busy", busy, 0);
      chk("midrst_exe_op", exe_op, 0);
      exe_ready = 1'b1; exe_result = 32'hFFFFFFFF;
      @(negedge clock);
      exe_ready = 1'b0;
      chk("midrst_kill", exe_kill, 0);

      // Randomised ops.
      for (int n = 0; n < 60; n++) begin
         int dly, fl;
         dly = $urandom_range(0, MAXD);
         fl  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAXD) : NONE;
         run_op(OPW'($urandom), $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
                1'($urandom), 1'($urandom), 1'($urandom), dly, fl, $urandom, 5'($urandom),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
      end

`ifdef FPU_ISSUE_WDOG_EN
      // Watchdog: execute never answers.
      begin
         ev_t e;
         chk("wdog_err_before", err, 0);
         e.kill = 1; e.fwr = 0; e.iwr = 0; e.flg = 1; e.addr = 0; e.data = 0; e.flags = 5'b10000;
         eq.push_back(e);
         lq.push_back('{12'h5D5, 32'h7, 32'h8, 32'h9});
         in_op = 12'h5D5; in_data1 = 32'h7; in_data2 = 32'h8; in_data3 = 32'h9;
         in_waddr = 5'd2; in_fwren = 1'b1; in_wren = 1'b0; in_fpuf = 1'b1; in_valid = 1'b1;
         @(negedge clock);
         in_valid = 1'b0;
         repeat (TB_TIMEOUT) @(negedge clock);
         chk("wdog_err_last_wait", err, 0);
         chk("wdog_busy_last_wait", busy, 1);
         @(negedge clock);
         chk("wdog_err_set", err, 1);
         chk("wdog_idle", in_ready, 1);
         chk("wdog_busy_clear", busy, 0);
         @(negedge clock);
         chk("wdog_err_sticky", err, 1);
         reset = 1'b1;
         @(negedge clock);
         reset = 1'b0;
         chk("wdog_err_reset", err, 0);
      end
`endif

      repeat (5) @(negedge clock);
      chk("launch_queue_empty", lq.size(), 0);
      chk("event_queue_empty", eq.size(), 0);
      chk("err_final", err, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
